axis_udp_tx_builder: RTL and testbench

Transmit-side counterpart of the AXIS UDP receive/filter path. Takes a UDP payload stream on a 64-bit AXI4-Stream slave and emits a complete Ethernet II / IPv4 / UDP frame on a 64-bit AXI4-Stream master. The 42-byte header is built from static configuration inputs, and the payload is realigned behind it. Sits between the payload source and the MAC TX stream interface; the MAC handles preamble, padding and FCS.

---
 rtl/axis_udp_tx_builder.sv | 201 ++++++++++++++++++++
 tb/tb_axis_udp_tx_builder.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_udp_tx_builder.sv
// axis_udp_tx_builder: wraps a 64-bit AXIS UDP payload stream in an
// Ethernet II / IPv4 / UDP header (42 bytes) built from static config.
module axis_udp_tx_builder #(
  parameter int AXIS_DATA_WIDTH = 64
) (
  input  logic                         axis_aclk,
  input  logic                         axis_s_rst_n,
  input  logic                         en_i,
  input  logic [47:0]                  src_mac_i,
  input  logic [47:0]                  dst_mac_i,
  input  logic [31:0]                  src_ip_i,
  input  logic [31:0]                  dst_ip_i,
  input  logic [15:0]                  src_port_i,
  input  logic [15:0]                  dst_port_i,
  input  logic [15:0]                  payload_len_i,
  input  logic                         s_axis_tvalid,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic                         m_axis_tvalid,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [15:0] carry, carry_nxt;
  logic [1:0]  flush_strb, flush_strb_nxt;
  logic        latch_cfg;
  logic        load_en;

  logic        m_tvalid_nxt;
  logic [63:0] m_tdata_nxt;
  logic [7:0]  m_tstrb_nxt;
  logic        m_tlast_nxt;

  logic [47:0] src_mac_q, dst_mac_q;
  logic [31:0] src_ip_q, dst_ip_q;
  logic [15:0] src_port_q, dst_port_q, len_q;

  logic [15:0] ip_len, udp_len, ip_csum;
  logic [19:0] csum_sum;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;

  // Map a big-endian 8-byte word (first byte in [63:56]) onto lanes 0..7.
  function automatic logic [63:0] net(input logic [63:0] be);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[8*i +: 8] = be[63-8*i -: 8];
    end
    return r;
  endfunction

  // Length fields and IPv4 header checksum from the latched configuration.
  always_comb begin
    ip_len   = len_q + 16'd28;
    udp_len  = len_q + 16'd8;
    // Constant words 0x4500 + 0x4000 + 0x4011 folded into one term.
    csum_sum = 20'h0C511 + 20'(ip_len)
             + 20'(src_ip_q[31:16]) + 20'(src_ip_q[15:0])
             + 20'(dst_ip_q[31:16]) + 20'(dst_ip_q[15:0]);
    csum_f1  = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
    csum_f2  = csum_f1[15:0] + 16'(csum_f1[16]);
    ip_csum  = ~csum_f2;
  end

  assign load_en = !m_axis_tvalid || m_axis_tready;

  // Next-state, output-register and handshake logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    carry_nxt      = carry;
    flush_strb_nxt = flush_strb;
    latch_cfg      = 1'b0;
    s_axis_tready  = 1'b0;
    m_tvalid_nxt   = m_axis_tvalid;
    m_tdata_nxt    = m_axis_tdata;
    m_tstrb_nxt    = m_axis_tstrb;
    m_tlast_nxt    = m_axis_tlast;
    if (load_en) begin
      m_tvalid_nxt = 1'b0;
      m_tdata_nxt  = '0;
      m_tstrb_nxt  = '0;
      m_tlast_nxt  = 1'b0;
    end
    unique case (state)
      IDLE: begin
        // Start waits for the previous frame's last beat to drain, leaving an
        // idle bus cycle. Beat 0 comes from the live inputs so it is valid
        // one cycle after start; cnt tracks the beat held in the output reg.
        if (en_i && s_axis_tvalid && !m_axis_tvalid) begin
          latch_cfg    = 1'b1;
          cnt_nxt      = '0;
          carry_nxt    = '0;
          state_nxt    = HDR;
          m_tvalid_nxt = 1'b1;
          m_tdata_nxt  = net({dst_mac_i, src_mac_i[47:32]});
          m_tstrb_nxt  = '1;
        end
      end
      HDR: begin
        if (load_en) begin
          cnt_nxt      = cnt + 3'd1;
          m_tvalid_nxt = 1'b1;
          m_tstrb_nxt  = '1;
          unique case (cnt)
            3'd0:    m_tdata_nxt = net({src_mac_q[31:0], 16'h0800, 8'h45, 8'h00});
            3'd1:    m_tdata_nxt = net({ip_len, 16'h0000, 16'h4000, 8'h40, 8'h11});
            3'd2:    m_tdata_nxt = net({ip_csum, src_ip_q, dst_ip_q[31:16]});
            default: m_tdata_nxt = net({dst_ip_q[15:0], src_port_q, dst_port_q, udp_len});
          endcase
          if (cnt == 3'd3) begin
            state_nxt = PAYLOAD;
            carry_nxt = '0;
          end
        end
      end
      PAYLOAD: begin
        s_axis_tready = load_en;
        if (load_en && s_axis_tvalid) begin
          m_tvalid_nxt = 1'b1;
          m_tdata_nxt  = {s_axis_tdata[47:0], carry};
          m_tstrb_nxt  = '1;
          carry_nxt    = s_axis_tdata[63:48];
          if (s_axis_tlast) begin
            if (s_axis_tstrb[6]) begin
              flush_strb_nxt = s_axis_tstrb[7:6];
              state_nxt      = FLUSH;
            end else begin
              m_tstrb_nxt = {s_axis_tstrb[5:0], 2'b11};
              m_tlast_nxt = 1'b1;
              state_nxt   = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        if (load_en) begin
          m_tvalid_nxt = 1'b1;
          m_tdata_nxt  = {48'h0, carry};
          m_tstrb_nxt  = {6'h0, flush_strb};
          m_tlast_nxt  = 1'b1;
          state_nxt    = IDLE;
        end
      end
    endcase
  end

  // FSM state, beat counter, carry and registered master outputs.
  always_ff @(posedge axis_aclk or negedge axis_s_rst_n) begin
    if (!axis_s_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      carry         <= '0;
      flush_strb    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      carry         <= carry_nxt;
      flush_strb    <= flush_strb_nxt;
      m_axis_tvalid <= m_tvalid_nxt;
      m_axis_tdata  <= m_tdata_nxt;
      m_axis_tstrb  <= m_tstrb_nxt;
      m_axis_tlast  <= m_tlast_nxt;
    end
  end

  // Configuration snapshot taken at frame start.
  always_ff @(posedge axis_aclk or negedge axis_s_rst_n) begin
    if (!axis_s_rst_n) begin
      src_mac_q  <= '0;
      dst_mac_q  <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
      len_q      <= '0;
    end else if (latch_cfg) begin
      src_mac_q  <= src_mac_i;
      dst_mac_q  <= dst_mac_i;
      src_ip_q   <= src_ip_i;
      dst_ip_q   <= dst_ip_i;
      src_port_q <= src_port_i;
      dst_port_q <= dst_port_i;
      len_q      <= payload_len_i;
    end
  end

endmodule

// File: tb/tb_axis_udp_tx_builder.sv
// Directed bench for axis_udp_tx_builder: frame byte model plus
// hand-computed header values at the frame and beat level.
module tb_axis_udp_tx_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [47:0] src_mac = '0, dst_mac = '0;
  logic [31:0] src_ip = '0, dst_ip = '0;
  logic [15:0] src_port = '0, dst_port = '0, plen = '0;
  logic        s_tvalid = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tstrb = '0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic        m_tvalid;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb;
  logic        m_tlast;
  logic        m_tready = 1'b1;

  always #5 clk = ~clk;

  axis_udp_tx_builder #(.AXIS_DATA_WIDTH(64)) dut (
    .axis_aclk     (clk),
    .axis_s_rst_n  (rst_n),
    .en_i          (en),
    .src_mac_i     (src_mac),
    .dst_mac_i     (dst_mac),
    .src_ip_i      (src_ip),
    .dst_ip_i      (dst_ip),
    .src_port_i    (src_port),
    .dst_port_i    (dst_port),
    .payload_len_i (plen),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready)
  );

  int passed = 0;
  int total  = 0;

  logic [63:0] beat_d[$];
  logic [7:0]  beat_s[$];
  logic        beat_l[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  exp_q[$];
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_d = '0;
  logic [7:0]  prev_s = '0;
  logic        prev_l = 1'b0;
  logic        rand_ready = 1'b0;
  logic        ready_val = 1'b1;
  int          byte_err, first_bad, frame_err, got_len;

  // Sink ready: fixed or 50% random, changed just after the clock edge.
  always @(posedge clk) begin
    #1;
    m_tready <= rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Output monitor: records accepted beats and stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_d ||
                         m_tstrb !== prev_s || m_tlast !== prev_l))
        stall_err <= stall_err + 1;
      prev_stall <= m_tvalid && !m_tready;
      prev_d     <= m_tdata;
      prev_s     <= m_tstrb;
      prev_l     <= m_tlast;
      if (m_tvalid && m_tready) begin
        beat_d.push_back(m_tdata);
        beat_s.push_back(m_tstrb);
        beat_l.push_back(m_tlast);
      end
    end
  end

  task automatic set_cfg(input logic [15:0] len);
    dst_mac  = 48'hFFFFFFFFFFFF;
    src_mac  = 48'h000A35000001;
    src_ip   = 32'hC0A8010A;
    dst_ip   = 32'hC0A80101;
    src_port = 16'h1234;
    dst_port = 16'h5678;
    plen     = len;
  endtask

  task automatic fill_seq(input int n, input logic [7:0] start, input logic [7:0] step);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'(start + step * i));
  endtask

  task automatic fill_rand(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference frame: header bytes laid out field by field, then payload.
  task automatic build_exp();
    logic [7:0]  h[42];
    logic [15:0] tl, ul, ck;
    int unsigned sum;
    tl = plen + 16'd28;
    ul = plen + 16'd8;
    for (int i = 0; i < 6; i++) begin
      h[i]     = dst_mac[47-8*i -: 8];
      h[6+i]   = src_mac[47-8*i -: 8];
    end
    h[12] = 8'h08; h[13] = 8'h00; h[14] = 8'h45; h[15] = 8'h00;
    h[16] = tl[15:8]; h[17] = tl[7:0]; h[18] = 8'h00; h[19] = 8'h00;
    h[20] = 8'h40; h[21] = 8'h00; h[22] = 8'h40; h[23] = 8'h11;
    h[24] = 8'h00; h[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      h[26+i] = src_ip[31-8*i -: 8];
      h[30+i] = dst_ip[31-8*i -: 8];
    end
    h[34] = src_port[15:8]; h[35] = src_port[7:0];
    h[36] = dst_port[15:8]; h[37] = dst_port[7:0];
    h[38] = ul[15:8]; h[39] = ul[7:0]; h[40] = 8'h00; h[41] = 8'h00;
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {16'h0, h[i], h[i+1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~sum[15:0];
    h[24] = ck[15:8];
    h[25] = ck[7:0];
    exp_q.delete();
    for (int i = 0; i < 42; i++) exp_q.push_back(h[i]);
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
  endtask

  task automatic set_beat(input int b);
    int n = pay_q.size();
    s_tdata = '0;
    s_tstrb = '0;
    for (int j = 0; j < 8; j++) begin
      if (b*8 + j < n) begin
        s_tdata[8*j +: 8] = pay_q[b*8 + j];
        s_tstrb[j] = 1'b1;
      end
    end
    s_tlast = (b == (n + 7) / 8 - 1);
  endtask

  task automatic send_payload(input bit rnd, input bit drop_en, input string name);
    int n  = pay_q.size();
    int nb = (n + 7) / 8;
    int b  = 0;
    int g  = 0;
    set_beat(0);
    s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    en = 1'b1;
    while (b < nb && g < 20000) begin
      @(negedge clk);
      if (s_tvalid && s_tready) b++;
      @(posedge clk);
      #1;
      if (drop_en && m_tvalid) en = 1'b0;
      if (b < nb) begin
        set_beat(b);
        s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        s_tvalid = 1'b0;
      end
      g++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    en       = 1'b0;
    if (b < nb) begin
      total++;
      $display("FAIL %s_send: accepted %0d input beats, want %0d", name, b, nb);
    end
  endtask

  task automatic wait_frame(input int base, input string name);
    int g = 0;
    while (!(beat_l.size() > base && beat_l[beat_l.size()-1] == 1'b1) && g < 5000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 5000) begin
      total++;
      $display("FAIL %s_tlast: no tlast beat within 5000 cycles, got %0d beats", name, beat_d.size() - base);
    end
    @(posedge clk);
    #1;
  endtask

  // Flatten accepted beats by strobe into bytes and diff against exp_q.
  task automatic flatten(input int base);
    logic [7:0]  got[$];
    logic [63:0] d;
    logic [7:0]  s;
    int nb = beat_d.size() - base;
    byte_err = 0; first_bad = -1; frame_err = 0;
    for (int i = 0; i < nb; i++) begin
      d = beat_d[base+i];
      s = beat_s[base+i];
      for (int j = 0; j < 8; j++) if (s[j]) got.push_back(d[8*j +: 8]);
      if (i < nb - 1) begin
        if (beat_l[base+i] || s != 8'hFF) frame_err++;
      end else if (!beat_l[base+i] || s == 8'h00 || ((s + 8'h01) & s) != 8'h00) begin
        frame_err++;
      end
    end
    if (nb == 0) frame_err++;
    got_len = got.size();
    if (got.size() != exp_q.size()) byte_err++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      if (got[i] !== exp_q[i]) begin
        if (first_bad < 0) first_bad = i;
        byte_err++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_tvalid); else passed++;
    total++; if (m_tdata !== 64'h0) $display("FAIL reset_tdata: got %h want 0", m_tdata); else passed++;
    total++; if (m_tstrb !== 8'h00) $display("FAIL reset_tstrb: got %h want 00", m_tstrb); else passed++;
    total++; if (m_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", m_tlast); else passed++;
    total++; if (s_tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", s_tready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int base;
    logic [63:0] d;
    set_cfg(16'd8);
    fill_seq(8, 8'h11, 8'h11);
    build_exp();
    base = beat_d.size();
    send_payload(1'b0, 1'b0, "basic");
    wait_frame(base, "basic");
    flatten(base);
    total++; if (beat_d.size() - base !== 7) $display("FAIL basic_beats: got %0d want 7", beat_d.size() - base); else passed++;
    total++; if (byte_err !== 0) $display("FAIL basic_bytes: %0d errors first at %0d, got %0d bytes want 50", byte_err, first_bad, got_len); else passed++;
    total++; if (frame_err !== 0) $display("FAIL basic_framing: %0d strb/tlast errors want 0", frame_err); else passed++;
    if (beat_d.size() - base >= 7) begin
      d = beat_d[base+2];
      total++; if ({d[7:0], d[15:8]} !== 16'h0024) $display("FAIL basic_iplen: got %h want 0024", {d[7:0], d[15:8]}); else passed++;
      total++; if (beat_d[base+3] !== 64'hA8C00A01A8C06DB7) $display("FAIL basic_beat3: got %h want a8c00a01a8c06db7", beat_d[base+3]); else passed++;
      d = beat_d[base+4];
      total++; if ({d[55:48], d[63:56]} !== 16'h0010) $display("FAIL basic_udplen: got %h want 0010", {d[55:48], d[63:56]}); else passed++;
      total++; if (beat_d[base+5] !== 64'h6655443322110000 || beat_s[base+5] !== 8'hFF)
        $display("FAIL basic_beat5: got %h/%h want 6655443322110000/ff", beat_d[base+5], beat_s[base+5]); else passed++;
      total++; if (beat_s[base+6] !== 8'h03 || beat_l[base+6] !== 1'b1 || beat_d[base+6] !== 64'h8877)
        $display("FAIL basic_flush: got %h/%h/%b want 8877/03/1", beat_d[base+6], beat_s[base+6], beat_l[base+6]); else passed++;
    end else begin
      total++;
      $display("FAIL basic_short: got %0d beats want 7", beat_d.size() - base);
    end
  endtask

  task automatic test_short_payload();
    int base;
    logic [63:0] d;
    set_cfg(16'd3);
    fill_seq(3, 8'hA1, 8'h01);
    build_exp();
    base = beat_d.size();
    send_payload(1'b0, 1'b0, "short");
    wait_frame(base, "short");
    flatten(base);
    total++; if (beat_d.size() - base !== 6) $display("FAIL short_beats: got %0d want 6", beat_d.size() - base); else passed++;
    total++; if (byte_err !== 0) $display("FAIL short_bytes: %0d errors first at %0d, got %0d bytes want 45", byte_err, first_bad, got_len); else passed++;
    if (beat_d.size() - base >= 6) begin
      d = beat_d[base+2];
      total++; if ({d[7:0], d[15:8]} !== 16'h001F) $display("FAIL short_iplen: got %h want 001f", {d[7:0], d[15:8]}); else passed++;
      total++; if (beat_s[base+5] !== 8'h1F || beat_l[base+5] !== 1'b1)
        $display("FAIL short_last: got strb %h tlast %b want 1f/1", beat_s[base+5], beat_l[base+5]); else passed++;
    end
  endtask

  task automatic test_two_beat();
    int base;
    set_cfg(16'd14);
    fill_seq(14, 8'h40, 8'h03);
    build_exp();
    base = beat_d.size();
    send_payload(1'b0, 1'b0, "two");
    wait_frame(base, "two");
    flatten(base);
    total++; if (beat_d.size() - base !== 7) $display("FAIL two_beats: got %0d want 7", beat_d.size() - base); else passed++;
    total++; if (byte_err !== 0) $display("FAIL two_bytes: %0d errors first at %0d, got %0d bytes want 56", byte_err, first_bad, got_len); else passed++;
    if (beat_d.size() - base >= 7) begin
      total++; if (beat_s[base+6] !== 8'hFF || beat_l[base+6] !== 1'b1)
        $display("FAIL two_last: got strb %h tlast %b want ff/1", beat_s[base+6], beat_l[base+6]); else passed++;
    end
  endtask

  task automatic test_enable_gate();
    int base, bad;
    set_cfg(16'd8);
    fill_seq(8, 8'h01, 8'h01);
    build_exp();
    en = 1'b0;
    set_beat(0);
    s_tvalid = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_tready !== 1'b0 || m_tvalid !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL gate_idle: %0d cycles with tready/tvalid high want 0", bad); else passed++;
    base = beat_d.size();
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    total++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h0A00FFFFFFFFFFFF)
      $display("FAIL gate_start: got tvalid %b tdata %h want 1/0a00ffffffffffff", m_tvalid, m_tdata); else passed++;
    send_payload(1'b0, 1'b0, "gate");
    wait_frame(base, "gate");
    flatten(base);
    total++; if (byte_err !== 0) $display("FAIL gate_bytes: %0d errors first at %0d, got %0d bytes want 50", byte_err, first_bad, got_len); else passed++;
  endtask

  task automatic test_back_to_back();
    int base;
    set_cfg(16'd16);
    fill_seq(16, 8'h90, 8'h05);
    build_exp();
    base = beat_d.size();
    fork
      send_payload(1'b0, 1'b1, "b2b_a");
      begin
        repeat (2) @(posedge clk);
        #2;
        src_ip   = 32'h0A000001;
        dst_port = 16'h9999;
        plen     = 16'd100;
      end
    join
    wait_frame(base, "b2b_a");
    flatten(base);
    total++; if (byte_err !== 0) $display("FAIL b2b_a_bytes: %0d errors first at %0d, got %0d bytes want 58", byte_err, first_bad, got_len); else passed++;
    total++; if (frame_err !== 0) $display("FAIL b2b_a_framing: %0d strb/tlast errors want 0", frame_err); else passed++;
    plen = 16'd7;
    fill_seq(7, 8'hC1, 8'h01);
    build_exp();
    base = beat_d.size();
    send_payload(1'b0, 1'b0, "b2b_b");
    wait_frame(base, "b2b_b");
    flatten(base);
    total++; if (byte_err !== 0) $display("FAIL b2b_b_bytes: %0d errors first at %0d, got %0d bytes want 49", byte_err, first_bad, got_len); else passed++;
    if (beat_d.size() - base >= 7) begin
      total++; if (beat_s[base+6] !== 8'h01 || beat_l[base+6] !== 1'b1)
        $display("FAIL b2b_b_flush: got strb %h tlast %b want 01/1", beat_s[base+6], beat_l[base+6]); else passed++;
    end else begin
      total++;
      $display("FAIL b2b_b_beats: got %0d want 7", beat_d.size() - base);
    end
  endtask

  task automatic test_random_stall();
    int base, s0;
    logic [63:0] d;
    set_cfg(16'd1472);
    fill_rand(1472);
    build_exp();
    base = beat_d.size();
    s0 = stall_err;
    rand_ready = 1'b1;
    send_payload(1'b1, 1'b0, "rand");
    wait_frame(base, "rand");
    rand_ready = 1'b0;
    flatten(base);
    total++; if (byte_err !== 0) $display("FAIL rand_bytes: %0d errors first at %0d, got %0d bytes want 1514", byte_err, first_bad, got_len); else passed++;
    total++; if (frame_err !== 0) $display("FAIL rand_framing: %0d strb/tlast errors want 0", frame_err); else passed++;
    total++; if (stall_err - s0 !== 0) $display("FAIL rand_stall: %0d held-output changes want 0", stall_err - s0); else passed++;
    if (beat_d.size() - base >= 4) begin
      d = beat_d[base+3];
      total++; if (d[15:0] !== 16'hB5B1) $display("FAIL rand_csum: got lanes %h want b5b1", d[15:0]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int base, b, g;
    set_cfg(16'd24);
    fill_seq(24, 8'h20, 8'h01);
    set_beat(0);
    s_tvalid = 1'b1;
    en = 1'b1;
    b = 0;
    g = 0;
    while (b < 2 && g < 200) begin
      @(negedge clk);
      if (s_tready) b++;
      if (b < 2) begin
        @(posedge clk); #1;
        set_beat(b);
      end
      g++;
    end
    if (b < 2) begin
      total++;
      $display("FAIL rstmid_reach: accepted %0d input beats want 2", b);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if ({m_tvalid, m_tdata, m_tstrb, m_tlast, s_tready} !== 75'h0)
      $display("FAIL rstmid_outputs: got tvalid %b tdata %h tstrb %h tlast %b tready %b want all 0",
               m_tvalid, m_tdata, m_tstrb, m_tlast, s_tready); else passed++;
    s_tvalid = 1'b0;
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_cfg(16'd14);
    fill_rand(14);
    build_exp();
    base = beat_d.size();
    rand_ready = 1'b1;
    send_payload(1'b0, 1'b0, "rstmid");
    wait_frame(base, "rstmid");
    rand_ready = 1'b0;
    flatten(base);
    total++; if (byte_err !== 0) $display("FAIL rstmid_bytes: %0d errors first at %0d, got %0d bytes want 56", byte_err, first_bad, got_len); else passed++;
    total++; if (frame_err !== 0) $display("FAIL rstmid_framing: %0d strb/tlast errors want 0", frame_err); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_payload();
    test_two_beat();
    test_enable_gate();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
